// File: rtl/regread_sched.sv
// regread_sched: round-robin scheduler for one bank's asynchronous SRAM read port,
// with a one-entry tagged cache per requester that is invalidated by bank writes.
module regread_sched #(
  parameter int NPORT = 4,
  parameter int AW    = 8,
  parameter int DW    = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT*AW-1:0] addr,
  output logic [NPORT-1:0]    rd_valid,
  output logic [NPORT*DW-1:0] rd_data,
  input  logic                flush,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  output logic [AW-1:0]       sram_ra,
  input  logic [DW-1:0]       sram_rd
);
  localparam int PW = NPORT > 1 ? $clog2(NPORT) : 1;
  logic [AW-1:0]    addr_a [NPORT];
  logic [AW-1:0]    tag_q  [NPORT];
  logic [DW-1:0]    data_q [NPORT];
  logic [NPORT-1:0] cv_q, cv_d, pend_q, pend_d, hit, elig;
  logic [PW-1:0]    last_q, fill_port_q, gnt, idx;
  logic             gnt_v, fill_v_q, fill_ok;
  logic [AW-1:0]    sram_ra_q;
  assign elig     = req & ~hit & ~pend_q;
  assign rd_valid = hit;
  assign sram_ra  = sram_ra_q;
  // A write landing in the capture cycle means sram_rd is pre-write data.
  assign fill_ok  = ~(we && wa == sram_ra_q) & ~flush;
  for (genvar i = 0; i < NPORT; i++) begin : g_port
    logic fill_here;
    assign addr_a[i]              = addr[i*AW +: AW];
    assign hit[i]                 = cv_q[i] && tag_q[i] == addr_a[i];
    assign rd_data[i*DW +: DW]    = data_q[i];
    assign fill_here              = fill_v_q && fill_port_q == PW'(i);
    assign cv_d[i]                = fill_here ? fill_ok : cv_q[i] & ~(we && tag_q[i] == wa) & ~flush;
    assign pend_d[i]              = (pend_q[i] & ~fill_here) | (gnt_v && gnt == PW'(i));
  end
  always_comb begin
    gnt_v = 1'b0;
    gnt   = last_q;
    idx   = '0;
    for (int k = 1; k <= NPORT; k++) begin
      idx = PW'((int'(last_q) + k) % NPORT);
      if (!gnt_v && elig[idx]) begin
        gnt_v = 1'b1;
        gnt   = idx;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NPORT; k++) begin
        tag_q[k]  <= '0;
        data_q[k] <= '0;
      end
      cv_q        <= '0;
      pend_q      <= '0;
      last_q      <= PW'(NPORT - 1);
      fill_port_q <= '0;
      fill_v_q    <= 1'b0;
      sram_ra_q   <= '0;
    end else begin
      cv_q     <= cv_d;
      pend_q   <= pend_d;
      fill_v_q <= gnt_v;
      if (gnt_v) begin
        sram_ra_q   <= addr_a[gnt];
        fill_port_q <= gnt;
        last_q      <= gnt;
      end
      if (fill_v_q) begin
        tag_q[fill_port_q]  <= sram_ra_q;
        data_q[fill_port_q] <= sram_rd;
      end
    end
  end
endmodule

// File: tb/tb_regread_sched.sv
// tb_regread_sched: directed checks of grant order, fill latency, write/flush
// invalidation and asynchronous reset against a behavioural bank SRAM.
module tb_regread_sched;
  logic         clk;
  logic         reset_n;
  logic [3:0]   req;
  logic [31:0]  addr;
  logic [3:0]   rd_valid;
  logic [255:0] rd_data;
  logic         flush;
  logic         we;
  logic [7:0]   wa;
  logic [7:0]   sram_ra;
  logic [63:0]  sram_rd;
  logic [63:0]  mem [256];
  int           n_cmp = 0;
  int           n_bad = 0;

  regread_sched dut (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .flush(flush),
    .we(we), .wa(wa), .sram_ra(sram_ra), .sram_rd(sram_rd)
  );

  assign sram_rd = mem[sram_ra];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int p, input logic [7:0] a);
    addr[p*8 +: 8] = a;
  endtask

  function automatic logic [63:0] dat(input int p);
    return rd_data[p*64 +: 64];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; req = '0; addr = '0; flush = 1'b0; we = 1'b0; wa = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    tick(); tick();
    chk("rst_ra", 64'(sram_ra), 0);
    chk("rst_valid", 64'(rd_valid), 0);
    chk("rst_data_nonzero", 64'(rd_data != '0), 0);
    // single miss, latency 2
    reset_n = 1'b1;
    mem[5] = 64'hAAAA;
    req = 4'b0001; set_addr(0, 5);
    #1 chk("t1_c0_valid", 64'(rd_valid), 0);
    tick(); chk("t1_c1_ra", 64'(sram_ra), 5); chk("t1_c1_valid", 64'(rd_valid), 0);
    tick(); chk("t1_c2_valid", 64'(rd_valid), 1); chk("t1_c2_data", dat(0), 64'hAAAA);
    mem[5] = 64'hBBBB;
    tick(); tick();
    chk("t1_hold_valid", 64'(rd_valid), 1); chk("t1_hold_data", dat(0), 64'hAAAA);
    // four simultaneous misses after a fresh reset
    reset_n = 1'b0; #1 reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) mem[i] = 64'(i * 'h11);
    req = 4'hF;
    for (int p = 0; p < 4; p++) set_addr(p, 8'(p + 1));
    tick(); chk("t2_ra0", 64'(sram_ra), 1); chk("t2_v0", 64'(rd_valid), 4'b0000);
    tick(); chk("t2_ra1", 64'(sram_ra), 2); chk("t2_v1", 64'(rd_valid), 4'b0001);
    tick(); chk("t2_ra2", 64'(sram_ra), 3); chk("t2_v2", 64'(rd_valid), 4'b0011);
    tick(); chk("t2_ra3", 64'(sram_ra), 4); chk("t2_v3", 64'(rd_valid), 4'b0111);
    tick(); chk("t2_v4", 64'(rd_valid), 4'b1111);
    chk("t2_d2", dat(2), 64'h33); chk("t2_d3", dat(3), 64'h44);
    mem[12] = 64'hC0; set_addr(2, 12);
    tick(); chk("t2_p2_ra", 64'(sram_ra), 12); chk("t2_p2_v", 64'(rd_valid), 4'b1011);
    tick(); chk("t2_p2_v2", 64'(rd_valid), 4'b1111); chk("t2_p2_d", dat(2), 64'hC0);
    mem[10] = 64'hA0; mem[13] = 64'hD0; mem[14] = 64'hE0;
    set_addr(0, 10); set_addr(2, 14); set_addr(3, 13);
    tick(); chk("t2_rr_ra3", 64'(sram_ra), 13);
    tick(); chk("t2_rr_ra0", 64'(sram_ra), 10); chk("t2_rr_v0", 64'(rd_valid), 4'b1010);
    tick(); chk("t2_rr_ra2", 64'(sram_ra), 14); chk("t2_rr_v1", 64'(rd_valid), 4'b1011);
    tick(); chk("t2_rr_v2", 64'(rd_valid), 4'b1111);
    chk("t2_rr_d0", dat(0), 64'hA0); chk("t2_rr_d2", dat(2), 64'hE0); chk("t2_rr_d3", dat(3), 64'hD0);
    // write invalidates a valid entry, refetch sees new data
    mem[7] = 64'h77; set_addr(1, 7);
    tick(); chk("t3_ra", 64'(sram_ra), 7);
    tick(); chk("t3_v", 64'(rd_valid), 4'b1111); chk("t3_d", dat(1), 64'h77);
    we = 1'b1; wa = 8'd7;
    #1 chk("t3_wcycle_v", 64'(rd_valid), 4'b1111);
    tick(); we = 1'b0; mem[7] = 64'h55;
    chk("t3_inval_v", 64'(rd_valid), 4'b1101);
    tick(); chk("t3_refetch_ra", 64'(sram_ra), 7);
    tick(); chk("t3_refetch_v", 64'(rd_valid), 4'b1111); chk("t3_refetch_d", dat(1), 64'h55);
    // write in the capture cycle discards the fill
    mem[9] = 64'h90; set_addr(0, 9);
    tick(); chk("t4_ra", 64'(sram_ra), 9);
    we = 1'b1; wa = 8'd9;
    tick(); we = 1'b0; mem[9] = 64'h99;
    chk("t4_discard_v", 64'(rd_valid), 4'b1110);
    tick(); chk("t4_regrant_ra", 64'(sram_ra), 9); chk("t4_regrant_v", 64'(rd_valid), 4'b1110);
    tick(); chk("t4_final_v", 64'(rd_valid), 4'b1111); chk("t4_final_d", dat(0), 64'h99);
    // address change during fill
    mem[6] = 64'h66; set_addr(0, 5);
    tick(); chk("t5_ra_old", 64'(sram_ra), 5);
    set_addr(0, 6);
    #1 chk("t5_chg_v", 64'(rd_valid), 4'b1110);
    tick(); chk("t5_stale_v", 64'(rd_valid), 4'b1110); chk("t5_stale_d", dat(0), 64'hBBBB);
    tick(); chk("t5_ra_new", 64'(sram_ra), 6);
    tick(); chk("t5_new_v", 64'(rd_valid), 4'b1111); chk("t5_new_d", dat(0), 64'h66);
    // flush, then asynchronous reset during a fill
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("t6_flush_v", 64'(rd_valid), 4'b0000);
    tick(); chk("t6_ra1", 64'(sram_ra), 7);
    tick(); chk("t6_ra2", 64'(sram_ra), 14); chk("t6_v", 64'(rd_valid), 4'b0010);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_arst_ra", 64'(sram_ra), 0);
    chk("t6_arst_v", 64'(rd_valid), 0);
    chk("t6_arst_data_nonzero", 64'(rd_data != '0), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
